spi_frame_rx: RTL



---
 rtl/spi_frame_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI slave frame receiver with length/checksum validation
// Oversamples SCLK/CS/MOSI in the clk domain and publishes good frames on DATA.
module spi_frame_rx #(
    parameter int N_BYTES     = 51,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_EDGE = 0,
    parameter int CHK_EN      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   SCLK,
    input  logic                   CS,
    input  logic                   MOSI,
    output logic [8*N_BYTES-1:0]   DATA,
    output logic                   SPI_WR,
    output logic                   ERR,
    output logic [1:0]             ERR_CODE,
    output logic [15:0]            FRAME_CNT,
    output logic                   BUSY
);
    localparam int FRAME_BITS = 8 * N_BYTES;
    localparam int BCW        = $clog2(FRAME_BITS + 1);
    localparam int SETTLE     = SYNC_STAGES + 2;
    localparam int SCW        = $clog2(SETTLE + 1);

    localparam logic [1:0] S_SKIP  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_RECV  = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_prev, r_cs_prev;
    logic                   r_sclk_edge, r_cs_rise, r_cs_fall, r_mosi_smp;
    logic [1:0]             r_state;
    logic [SCW-1:0]         r_settle;
    logic [BCW-1:0]         r_bit_cnt;
    logic [7:0]             r_byte_cnt, r_shift, r_xor;
    logic                   r_overrun;
    logic [FRAME_BITS-1:0]  r_buf, r_data;
    logic                   r_spi_wr, r_err;
    logic [1:0]             r_err_code;
    logic [15:0]            r_frame_cnt;

    logic       w_sclk_s, w_cs_s, w_mosi_s, w_sclk_sel, w_start, w_full, w_last_bit;
    logic [7:0] w_byte;

    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_sel = (SAMPLE_EDGE != 0) ? (r_sclk_prev & ~w_sclk_s) : (~r_sclk_prev & w_sclk_s);
    // A CS fall seen while CHECK runs must start the next frame, not be dropped.
    assign w_start    = r_cs_fall && ((r_state == S_IDLE) || (r_state == S_CHECK));
    assign w_full     = (r_byte_cnt == 8'(N_BYTES));
    assign w_last_bit = (r_bit_cnt[2:0] == 3'd7);
    assign w_byte     = {r_shift[6:0], r_mosi_smp};

    assign DATA      = r_data;
    assign SPI_WR    = r_spi_wr;
    assign ERR       = r_err;
    assign ERR_CODE  = r_err_code;
    assign FRAME_CNT = r_frame_cnt;
    assign BUSY      = (r_state == S_RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_sclk_edge <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_mosi_smp  <= 1'b0;
            r_state     <= S_SKIP;
            r_settle    <= SCW'(SETTLE);
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_xor       <= '0;
            r_overrun   <= 1'b0;
            r_buf       <= '0;
            r_data      <= '0;
            r_spi_wr    <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
            r_frame_cnt <= '0;
        end else begin
            // Strobes self-clear every cycle so a frozen clk_en can never stretch them.
            r_spi_wr <= 1'b0;
            r_err    <= 1'b0;
            if (clk_en) begin
                r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
                r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
                r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
                r_sclk_prev <= w_sclk_s;
                r_cs_prev   <= w_cs_s;
                r_sclk_edge <= w_sclk_sel;
                r_cs_rise   <= w_cs_s & ~r_cs_prev;
                r_cs_fall   <= ~w_cs_s & r_cs_prev;
                r_mosi_smp  <= w_mosi_s;

                if (r_state == S_CHECK) begin
                    if (r_bit_cnt == '0 && !r_overrun) begin
                        r_err <= 1'b0;
                    end else if (r_overrun) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                    end else if (r_bit_cnt != BCW'(FRAME_BITS)) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                    end else if (CHK_EN != 0 && r_buf[7:0] != r_xor) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd3;
                    end else begin
                        r_data      <= r_buf;
                        r_spi_wr    <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end

                if (w_start) begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                    r_shift    <= '0;
                    r_xor      <= '0;
                    r_overrun  <= 1'b0;
                    r_state    <= S_RECV;
                end else begin
                    case (r_state)
                        S_SKIP: begin
                            // Wait for the synchroniser to flush its reset value before trusting CS.
                            if (r_settle != '0)
                                r_settle <= r_settle - 1'b1;
                            else if (w_cs_s)
                                r_state <= S_IDLE;
                        end
                        S_IDLE: r_state <= S_IDLE;
                        S_RECV: begin
                            if (r_cs_rise) begin
                                r_state <= S_CHECK;
                            end else if (r_sclk_edge) begin
                                if (w_full) begin
                                    r_overrun <= 1'b1;
                                end else begin
                                    r_shift   <= w_byte;
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                    if (w_last_bit) begin
                                        for (int i = 0; i < N_BYTES; i++)
                                            if (r_byte_cnt == 8'(i))
                                                r_buf[8*(N_BYTES-1-i) +: 8] <= w_byte;
                                        if (r_byte_cnt < 8'(N_BYTES - 1))
                                            r_xor <= r_xor ^ w_byte;
                                        r_byte_cnt <= r_byte_cnt + 8'd1;
                                    end
                                end
                            end
                        end
                        S_CHECK: r_state <= S_IDLE;
                        default: r_state <= S_SKIP;
                    endcase
                end
            end
        end
    end
endmodule
